// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data bundle for one side of a pipeline stage.
// The master drives valid and data. The slave drives ready.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 96
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with a 2-entry skid buffer (main + skid).
// It supports flush-to-bubble and a saturating count of squashed entries.
module pipe_stage_reg #(
    parameter int              DATA_W        = 96,
    parameter logic [DATA_W-1:0] BUBBLE      = '0,
    parameter bit              FLUSH_KEEP_IN = 1'b0,
    parameter int              CNT_W         = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    pipe_stage_reg_if.slave      in_if,
    pipe_stage_reg_if.master     out_if,
    input  logic                 flush,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     squash_cnt
);

    // State is {main valid, skid valid}. {0,1} is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    localparam logic [CNT_W+1:0] CNT_MAX = (CNT_W+2)'({CNT_W{1'b1}});

    logic              mainValid_q, mainValid_d;
    logic              skidValid_q, skidValid_d;
    logic [DATA_W-1:0] mainData_q,  mainData_d;
    logic [DATA_W-1:0] skidData_q,  skidData_d;
    logic [1:0]        occupancy_q, occupancy_d;
    logic [CNT_W-1:0]  squashCnt_q, squashCnt_d;

    logic              acc;
    logic              take;
    logic [1:0]        dropped;
    logic [CNT_W+1:0]  cntSum;
    logic [1:0]        state;

    assign state = {mainValid_q, skidValid_q};
    assign acc   = in_if.valid & ~skidValid_q;
    assign take  = mainValid_q & out_if.ready;

    // in_ready comes straight from the skid flop, so downstream stalls never
    // reach upstream through combinational logic.
    always_comb begin
        mainValid_d = mainValid_q;
        skidValid_d = skidValid_q;
        mainData_d  = mainData_q;
        skidData_d  = skidData_q;
        dropped     = 2'd0;

        if (flush) begin
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
            mainData_d  = BUBBLE;
            skidData_d  = BUBBLE;
            dropped     = 2'(mainValid_q & ~take) + 2'(skidValid_q)
                        + 2'(acc & ~FLUSH_KEEP_IN);
            if (FLUSH_KEEP_IN && acc) begin
                mainValid_d = 1'b1;
                mainData_d  = in_if.data;
            end
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        mainValid_d = 1'b1;
                        mainData_d  = in_if.data;
                    end
                end
                ST_ONE: begin
                    if (take && acc) begin
                        mainData_d = in_if.data;
                    end else if (take) begin
                        mainValid_d = 1'b0;
                        mainData_d  = BUBBLE;
                    end else if (acc) begin
                        skidValid_d = 1'b1;
                        skidData_d  = in_if.data;
                    end
                end
                ST_FULL: begin
                    if (take) begin
                        mainData_d  = skidData_q;
                        skidValid_d = 1'b0;
                        skidData_d  = BUBBLE;
                    end
                end
                default: begin
                    mainValid_d = 1'b0;
                    skidValid_d = 1'b0;
                    mainData_d  = BUBBLE;
                    skidData_d  = BUBBLE;
                end
            endcase
        end
    end

    always_comb begin
        cntSum = (CNT_W+2)'(squashCnt_q) + (CNT_W+2)'(dropped);
        if (cntSum > CNT_MAX) begin
            squashCnt_d = {CNT_W{1'b1}};
        end else begin
            squashCnt_d = cntSum[CNT_W-1:0];
        end
        occupancy_d = 2'(mainValid_d) + 2'(skidValid_d);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            mainData_q  <= BUBBLE;
            skidData_q  <= BUBBLE;
            occupancy_q <= 2'd0;
            squashCnt_q <= '0;
        end else begin
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            mainData_q  <= mainData_d;
            skidData_q  <= skidData_d;
            occupancy_q <= occupancy_d;
            squashCnt_q <= squashCnt_d;
        end
    end

    assign in_if.ready  = ~skidValid_q;
    assign out_if.valid = mainValid_q;
    assign out_if.data  = mainData_q;
    assign occupancy    = occupancy_q;
    assign squash_cnt   = squashCnt_q;

    // The skid entry is always younger than main and never exists alone.
    assert property (@(posedge CLK) disable iff (!nRST) skidValid_q |-> mainValid_q);
    assert property (@(posedge CLK) disable iff (!nRST) !mainValid_q |-> (mainData_q == BUBBLE));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed scoreboard bench for pipe_stage_reg with three configurations:
// default, FLUSH_KEEP_IN=1, and CNT_W=2. All three share the same input stimulus.
module tb_pipe_stage_reg;

    localparam int DATA_W = 96;
    localparam int NDUT   = 3;
    localparam logic [DATA_W-1:0] BUBBLE    = '0;
    localparam logic [DATA_W-1:0] PAT_FIRST = 96'h00000040_8C220004_00000044;
    localparam logic [DATA_W-1:0] PAT_A     = 96'h000000A0_000000A1_000000A2;
    localparam logic [DATA_W-1:0] PAT_B     = 96'h000000B0_000000B1_000000B2;
    localparam logic [DATA_W-1:0] PAT_C     = 96'h000000C0_000000C1_000000C2;
    localparam logic [DATA_W-1:0] PAT_T     = 96'h0000007E_0000007E_0000007E;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic              inValid  = 1'b0;
    logic [DATA_W-1:0] inData   = '0;
    logic              outReady = 1'b0;
    logic              flush    = 1'b0;
    bit                checking = 1'b0;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg_if #(.DATA_W(DATA_W)) upIf0 ();
    pipe_stage_reg_if #(.DATA_W(DATA_W)) dnIf0 ();
    pipe_stage_reg_if #(.DATA_W(DATA_W)) upIf1 ();
    pipe_stage_reg_if #(.DATA_W(DATA_W)) dnIf1 ();
    pipe_stage_reg_if #(.DATA_W(DATA_W)) upIf2 ();
    pipe_stage_reg_if #(.DATA_W(DATA_W)) dnIf2 ();

    logic [1:0]  occ0, occ1, occ2;
    logic [15:0] sq0, sq1;
    logic [1:0]  sq2;

    assign upIf0.valid = inValid;  assign upIf0.data = inData;  assign dnIf0.ready = outReady;
    assign upIf1.valid = inValid;  assign upIf1.data = inData;  assign dnIf1.ready = outReady;
    assign upIf2.valid = inValid;  assign upIf2.data = inData;  assign dnIf2.ready = outReady;

    pipe_stage_reg #(.DATA_W(DATA_W), .BUBBLE(BUBBLE), .FLUSH_KEEP_IN(1'b0), .CNT_W(16)) dut0 (
        .CLK(CLK), .nRST(nRST), .in_if(upIf0), .out_if(dnIf0),
        .flush(flush), .occupancy(occ0), .squash_cnt(sq0));
    pipe_stage_reg #(.DATA_W(DATA_W), .BUBBLE(BUBBLE), .FLUSH_KEEP_IN(1'b1), .CNT_W(16)) dut1 (
        .CLK(CLK), .nRST(nRST), .in_if(upIf1), .out_if(dnIf1),
        .flush(flush), .occupancy(occ1), .squash_cnt(sq1));
    pipe_stage_reg #(.DATA_W(DATA_W), .BUBBLE(BUBBLE), .FLUSH_KEEP_IN(1'b0), .CNT_W(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .in_if(upIf2), .out_if(dnIf2),
        .flush(flush), .occupancy(occ2), .squash_cnt(sq2));

    logic              dutOutValid [NDUT];
    logic [DATA_W-1:0] dutOutData  [NDUT];
    logic              dutInReady  [NDUT];
    logic [1:0]        dutOcc      [NDUT];
    logic [15:0]       dutSquash   [NDUT];

    assign dutOutValid[0] = dnIf0.valid;  assign dutOutData[0] = dnIf0.data;  assign dutInReady[0] = upIf0.ready;
    assign dutOutValid[1] = dnIf1.valid;  assign dutOutData[1] = dnIf1.data;  assign dutInReady[1] = upIf1.ready;
    assign dutOutValid[2] = dnIf2.valid;  assign dutOutData[2] = dnIf2.data;  assign dutInReady[2] = upIf2.ready;
    assign dutOcc[0] = occ0;  assign dutOcc[1] = occ1;  assign dutOcc[2] = occ2;
    assign dutSquash[0] = sq0;  assign dutSquash[1] = sq1;  assign dutSquash[2] = {14'b0, sq2};

    // Reference model: each DUT is a FIFO of capacity two plus a saturating drop counter.
    logic [DATA_W-1:0] expQ [NDUT][$];
    int                expSquash  [NDUT];
    bit                modelReady [NDUT];

    function automatic bit keepOf(input int k);
        return (k == 1);
    endfunction

    function automatic int satOf(input int k);
        return (k == 2) ? 3 : 65535;
    endfunction

    task automatic checkVal(input string name, input int k,
                            input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %h, expected %h", name, k, act, exp);
        end
    endtask

    task automatic resetModel();
        for (int k = 0; k < NDUT; k++) begin
            expQ[k].delete();
            expSquash[k] = 0;
        end
    endtask

    // The monitor compares the present outputs against the model and pops an entry on each take.
    task automatic checkOutput();
        for (int k = 0; k < NDUT; k++) begin
            int n;
            n = expQ[k].size();
            checkVal("in_ready",   k, DATA_W'(dutInReady[k]),  DATA_W'(n < 2));
            checkVal("out_valid",  k, DATA_W'(dutOutValid[k]), DATA_W'(n > 0));
            checkVal("occupancy",  k, DATA_W'(dutOcc[k]),      DATA_W'(n));
            checkVal("squash_cnt", k, DATA_W'(dutSquash[k]),   DATA_W'(expSquash[k]));
            if (n > 0) begin
                checkVal("out_data", k, dutOutData[k], expQ[k][0]);
                if (outReady) void'(expQ[k].pop_front());
            end else begin
                checkVal("out_bubble", k, dutOutData[k], BUBBLE);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (checking) checkOutput();
    end

    // Inputs are driven 1 time unit after the rising edge. The model is advanced late in the cycle,
    // after the monitor has run.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                 input logic r, input logic f);
        @(posedge CLK);
        #1;
        inValid  = v;
        inData   = d;
        outReady = r;
        flush    = f;
        for (int k = 0; k < NDUT; k++) modelReady[k] = (expQ[k].size() < 2);
        #7;
        for (int k = 0; k < NDUT; k++) begin
            bit acc;
            int dropped;
            acc = inValid && modelReady[k];
            if (flush) begin
                dropped = expQ[k].size() + ((acc && !keepOf(k)) ? 1 : 0);
                expQ[k].delete();
                if (acc && keepOf(k)) expQ[k].push_back(inData);
                expSquash[k] = (expSquash[k] + dropped > satOf(k)) ? satOf(k) : expSquash[k] + dropped;
            end else if (acc) begin
                expQ[k].push_back(inData);
            end
        end
    endtask

    task automatic checkResetNow();
        for (int k = 0; k < NDUT; k++) begin
            checkVal("async_out_valid",  k, DATA_W'(dutOutValid[k]), '0);
            checkVal("async_out_data",   k, dutOutData[k],           BUBBLE);
            checkVal("async_in_ready",   k, DATA_W'(dutInReady[k]),  DATA_W'(1));
            checkVal("async_occupancy",  k, DATA_W'(dutOcc[k]),      '0);
            checkVal("async_squash_cnt", k, DATA_W'(dutSquash[k]),   '0);
        end
    endtask

    function automatic logic [DATA_W-1:0] randData();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic randomPhase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus($urandom_range(0, 1) == 1, randData(),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        resetModel();
        #22;
        nRST = 1'b1;
        checking = 1'b1;
        $display("[TB] reset released");

        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, PAT_FIRST, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        applyStimulus(1'b1, PAT_A, 1'b1, 1'b0);
        applyStimulus(1'b1, PAT_B, 1'b1, 1'b0);
        applyStimulus(1'b1, PAT_C, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        applyStimulus(1'b1, PAT_A, 1'b0, 1'b0);
        applyStimulus(1'b1, PAT_B, 1'b0, 1'b0);
        applyStimulus(1'b1, PAT_C, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        applyStimulus(1'b1, PAT_A, 1'b0, 1'b0);
        applyStimulus(1'b1, PAT_B, 1'b0, 1'b0);
        applyStimulus(1'b1, PAT_C, 1'b0, 1'b1);
        applyStimulus(1'b1, PAT_A, 1'b0, 1'b0);
        applyStimulus(1'b1, PAT_T, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, randData(), 1'b0, 1'b0);
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b1);

        randomPhase(400);

        @(posedge CLK);
        #2;
        checking = 1'b0;
        nRST     = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        flush    = 1'b0;
        #1;
        checkResetNow();
        resetModel();
        @(negedge CLK);
        #2;
        nRST = 1'b1;
        checking = 1'b1;

        randomPhase(200);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        @(posedge CLK);
        checking = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
